buf_rd_32x64: RTL and testbench

Read-side controller for the 32-entry x 64-bit two-port bit-enable line buffer. A single `start_i` pulse launches a burst read of `len_i` consecutive entries beginning at `base_adr_i`. The block drives the RAM read port, absorbs the RAM's 1-cycle read latency in a 2-entry output FIFO, and presents the words as a valid/ready stream to the downstream consumer. It sits between the buffer macro and the consuming pipeline stage, alongside the producer that owns the write port.

---
 rtl/buf_rd_32x64.sv | 154 +++++++++++++++
 tb/tb_buf_rd_32x64.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_rd_32x64.sv
// Burst read controller for the 32x64 line buffer: issues RAM reads, absorbs the
// 1-cycle read latency in a 2-entry FIFO, streams words out. Option: BUF_RD_FWD_EN.
module buf_rd_32x64 #(
   parameter int ADR_WD = 5,
   parameter int DAT_WD = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADR_WD-1:0] base_adr_i,
   input  logic [ADR_WD:0]   len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              rd_ena_o,
   output logic [ADR_WD-1:0] rd_adr_o,
   input  logic [DAT_WD-1:0] rd_dat_i,
   input  logic [DAT_WD-1:0] wr_ena_i,
   input  logic [ADR_WD-1:0] wr_adr_i,
   input  logic [DAT_WD-1:0] wr_dat_i,
   output logic              val_o,
   output logic [DAT_WD-1:0] dat_o,
   output logic              last_o,
   input  logic              rdy_i
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [ADR_WD:0]     cnt_q;
   logic [ADR_WD-1:0]   adr_q;
   logic                infl_q, infl_last_q;
   logic [DAT_WD-1:0]   fifo_dat_q [2];
   logic                fifo_last_q [2];
   logic                rd_ptr_q, wr_ptr_q;
   logic [1:0]          fifo_cnt_q;
   logic                busy_q, done_q, done_d;
   logic [1:0]          occ;
   logic                pop, issue, final_issue, head_last;
   logic [DAT_WD-1:0]   push_dat;

   assign head_last   = fifo_last_q[rd_ptr_q];
   assign pop         = (fifo_cnt_q != 2'd0) && rdy_i;
   // Occupancy counts the read still in flight so the FIFO can never overflow.
   assign occ         = fifo_cnt_q + {1'b0, infl_q};
   assign issue       = (state_q == RUN) && ((occ < 2'd2) || pop);
   assign final_issue = issue && (cnt_q == (ADR_WD+1)'(1));

`ifdef BUF_RD_FWD_EN
   logic [DAT_WD-1:0] fwd_mask_q, fwd_dat_q;
   logic              fwd_hit;

   assign fwd_hit  = issue && (wr_ena_i != '0) && (wr_adr_i == adr_q);
   assign push_dat = (rd_dat_i & ~fwd_mask_q) | (fwd_dat_q & fwd_mask_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_mask_q <= '0;
         fwd_dat_q  <= '0;
      end else begin
         fwd_mask_q <= fwd_hit ? wr_ena_i : '0;
         fwd_dat_q  <= wr_dat_i;
      end
   end
`else
   logic unused_snoop;

   assign unused_snoop = ^{wr_ena_i, wr_adr_i, wr_dat_i};
   assign push_dat     = rd_dat_i;
`endif

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) state_d = RUN;
               else             done_d  = 1'b1;
            end
         end
         RUN: begin
            if (final_issue) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && head_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
         adr_q       <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= (state_d != IDLE);
         done_q      <= done_d;
         infl_q      <= issue;
         infl_last_q <= final_issue;
         if ((state_q == IDLE) && start_i) begin
            cnt_q <= len_i;
            adr_q <= base_adr_i;
         end else if (issue) begin
            cnt_q <= cnt_q - 1'b1;
            adr_q <= adr_q + 1'b1;
         end
      end
   end

   // NOTE: the two FIFO words are reset as well, because dat_o must read 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_dat_q[0]  <= '0;
         fifo_dat_q[1]  <= '0;
         fifo_last_q[0] <= 1'b0;
         fifo_last_q[1] <= 1'b0;
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         fifo_cnt_q     <= 2'd0;
      end else begin
         if (infl_q) begin
            fifo_dat_q[wr_ptr_q]  <= push_dat;
            fifo_last_q[wr_ptr_q] <= infl_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         case ({infl_q, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign rd_ena_o = issue;
   assign rd_adr_o = adr_q;
   assign val_o    = (fifo_cnt_q != 2'd0);
   assign dat_o    = fifo_dat_q[rd_ptr_q];
   assign last_o   = val_o && head_last;

endmodule

// File: tb/tb_buf_rd_32x64.sv
// Directed self-checking bench for buf_rd_32x64 with a 1-cycle-latency bit-enable RAM model.
module tb_buf_rd_32x64;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [4:0]  base_adr_i;
   logic [5:0]  len_i;
   logic        busy_o, done_o, rd_ena_o;
   logic [4:0]  rd_adr_o;
   logic [63:0] rd_dat_i;
   logic [63:0] wr_ena_i;
   logic [4:0]  wr_adr_i;
   logic [63:0] wr_dat_i;
   logic        val_o;
   logic [63:0] dat_o;
   logic        last_o;
   logic        rdy_i;

   logic        ram_init;
   logic [63:0] mem [32];
   logic [63:0] rd_dat_q;

   int checks = 0;
   int errors = 0;

   buf_rd_32x64 dut (
      .clk(clk), .rst(rst), .start_i(start_i), .base_adr_i(base_adr_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .rd_ena_o(rd_ena_o), .rd_adr_o(rd_adr_o),
      .rd_dat_i(rd_dat_i), .wr_ena_i(wr_ena_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
      .val_o(val_o), .dat_o(dat_o), .last_o(last_o), .rdy_i(rdy_i)
   );

   always #5 clk = ~clk;

   // Entry 7 holds zero so the collision case has a known old value.
   function automatic logic [63:0] word(input int a);
      int m;
      m = a % 32;
      if (m == 7) return 64'h0;
      return {16'hABCD, 16'(m), 16'h1234, 16'(m * 3 + 1)};
   endfunction

   // Read returns the pre-write contents on a same-cycle collision.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= word(i);
      end else begin
         if (rd_ena_o) rd_dat_q <= mem[rd_adr_o];
         for (int b = 0; b < 64; b++)
            if (wr_ena_i[b]) mem[wr_adr_i][b] <= wr_dat_i[b];
      end
   end
   assign rd_dat_i = rd_dat_q;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_done"}, 64'(done_o), 64'd0);
      check({tag, "_rd_ena"}, 64'(rd_ena_o), 64'd0);
      check({tag, "_rd_adr"}, 64'(rd_adr_o), 64'd0);
      check({tag, "_val"}, 64'(val_o), 64'd0);
      check({tag, "_dat"}, dat_o, 64'd0);
      check({tag, "_last"}, 64'(last_o), 64'd0);
   endtask

   // Full-rate burst: checks every cycle from S+1 to S+len+3 against the timing table.
   task automatic run_burst(input string tag, input int base, input int len);
      rdy_i      = 1'b1;
      start_i    = 1'b1;
      base_adr_i = 5'(base);
      len_i      = 6'(len);
      for (int c = 1; c <= len + 3; c++) begin
         tick();
         start_i = 1'b0;
         if (c <= len) begin
            check($sformatf("%s_rd_ena_c%0d", tag, c), 64'(rd_ena_o), 64'd1);
            check($sformatf("%s_rd_adr_c%0d", tag, c), 64'(rd_adr_o), 64'((base + c - 1) % 32));
         end else begin
            check($sformatf("%s_rd_ena_c%0d", tag, c), 64'(rd_ena_o), 64'd0);
         end
         if (c >= 3 && c <= len + 2) begin
            check($sformatf("%s_val_c%0d", tag, c), 64'(val_o), 64'd1);
            check($sformatf("%s_dat_c%0d", tag, c), dat_o, word(base + c - 3));
            check($sformatf("%s_last_c%0d", tag, c), 64'(last_o), 64'(c == len + 2));
         end else begin
            check($sformatf("%s_val_c%0d", tag, c), 64'(val_o), 64'd0);
         end
         check($sformatf("%s_done_c%0d", tag, c), 64'(done_o), 64'(c == len + 3));
         check($sformatf("%s_busy_c%0d", tag, c), 64'(busy_o), 64'(c <= len + 2));
      end
   endtask

   initial begin
      int issued, popped, occ;
      bit seen;
      logic [63:0] fwd_exp;

      rst        = 1'b1;
      ram_init   = 1'b1;
      start_i    = 1'b0;
      base_adr_i = '0;
      len_i      = '0;
      wr_ena_i   = '0;
      wr_adr_i   = '0;
      wr_dat_i   = '0;
      rdy_i      = 1'b1;
      tick();
      tick();
      check_idle_outputs("reset");
      rst      = 1'b0;
      ram_init = 1'b0;
      tick();

      // Whole buffer at full rate, then a burst that wraps 31 -> 0.
      run_burst("b0l32", 0, 32);
      run_burst("b30l4", 30, 4);

      // Random back-pressure: scoreboard against issued/popped counts.
      start_i    = 1'b1;
      base_adr_i = 5'd10;
      len_i      = 6'd8;
      tick();
      start_i = 1'b0;
      issued  = 0;
      popped  = 0;
      seen    = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         rdy_i = 1'($urandom_range(0, 1));
         #1;
         if (done_o) begin
            seen = 1'b1;
         end else begin
            occ = issued - popped;
            if (rd_ena_o) begin
               check($sformatf("stall_issue_ok_c%0d", c), 64'((occ < 2) || (val_o && rdy_i)), 64'd1);
               check($sformatf("stall_rd_adr_c%0d", c), 64'(rd_adr_o), 64'(10 + issued));
               issued++;
            end
            if (val_o) begin
               check($sformatf("stall_dat_c%0d", c), dat_o, word(10 + popped));
               check($sformatf("stall_last_c%0d", c), 64'(last_o), 64'(popped == 7));
               if (rdy_i) popped++;
            end
            tick();
         end
      end
      check("stall_done_seen", 64'(seen), 64'd1);
      check("stall_issued", 64'(issued), 64'd8);
      check("stall_popped", 64'(popped), 64'd8);
      check("stall_busy_end", 64'(busy_o), 64'd0);
      rdy_i = 1'b1;
      tick();

      // Empty burst: done next cycle, no read, no data.
      start_i    = 1'b1;
      base_adr_i = 5'd9;
      len_i      = 6'd0;
      tick();
      start_i = 1'b0;
      check("len0_done", 64'(done_o), 64'd1);
      check("len0_busy", 64'(busy_o), 64'd0);
      check("len0_rd_ena", 64'(rd_ena_o), 64'd0);
      check("len0_val", 64'(val_o), 64'd0);
      tick();
      check("len0_done_clr", 64'(done_o), 64'd0);
      check("len0_rd_ena2", 64'(rd_ena_o), 64'd0);

      // A start while busy must not relaunch or extend the burst.
      start_i    = 1'b1;
      base_adr_i = 5'd3;
      len_i      = 6'd2;
      tick();
      base_adr_i = 5'd20;
      len_i      = 6'd5;
      check("busy_ign_adr1", 64'(rd_adr_o), 64'd3);
      check("busy_ign_busy", 64'(busy_o), 64'd1);
      tick();
      start_i = 1'b0;
      check("busy_ign_adr2", 64'(rd_adr_o), 64'd4);
      tick();
      check("busy_ign_ena_off", 64'(rd_ena_o), 64'd0);
      check("busy_ign_dat1", dat_o, word(3));
      tick();
      check("busy_ign_dat2", dat_o, word(4));
      check("busy_ign_last", 64'(last_o), 64'd1);
      tick();
      check("busy_ign_done", 64'(done_o), 64'd1);
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("busy_ign_quiet_ena_c%0d", c), 64'(rd_ena_o), 64'd0);
         check($sformatf("busy_ign_quiet_busy_c%0d", c), 64'(busy_o), 64'd0);
      end

      // Reset on the third beat of a 16-word burst, then a clean short burst.
      start_i    = 1'b1;
      base_adr_i = 5'd0;
      len_i      = 6'd16;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check("rst_mid_beat3_dat", dat_o, word(2));
      rst = 1'b1;
      #1;
      check_idle_outputs("rst_mid");
      tick();
      rst = 1'b0;
      tick();
      run_burst("b5l2", 5, 2);

      // Same-cycle write to the entry being read.
`ifdef BUF_RD_FWD_EN
      fwd_exp = 64'h0000_0000_FFFF_FFFF;
`else
      fwd_exp = 64'h0;
`endif
      start_i    = 1'b1;
      base_adr_i = 5'd7;
      len_i      = 6'd1;
      tick();
      start_i = 1'b0;
      check("fwd_rd_ena", 64'(rd_ena_o), 64'd1);
      check("fwd_rd_adr", 64'(rd_adr_o), 64'd7);
      wr_ena_i = 64'h0000_0000_FFFF_FFFF;
      wr_adr_i = 5'd7;
      wr_dat_i = '1;
      tick();
      wr_ena_i = '0;
      wr_dat_i = '0;
      tick();
      check("fwd_val", 64'(val_o), 64'd1);
      check("fwd_dat", dat_o, fwd_exp);
      check("fwd_last", 64'(last_o), 64'd1);
      tick();
      check("fwd_done", 64'(done_o), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
